rob_commit: RTL and testbench



---
 rtl/rob_commit.sv | 124 ++++++++++++
 tb/tb_rob_commit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates positions at issue, records CDB completions,
// and retires one entry per cycle to the regfile, flushing on a mispredicted retire.
module rob_commit #(
    parameter int ROB_BITS = 4,
    parameter int DATA_W   = 32,
    parameter int REG_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ready,
    input  logic                alloc_valid,
    input  logic [REG_W-1:0]    alloc_rd,
    output logic                alloc_full,
    output logic [ROB_BITS-1:0] alloc_robpos,
    input  logic                cdb_valid,
    input  logic [ROB_BITS-1:0] cdb_robpos,
    input  logic [DATA_W-1:0]   cdb_val,
    input  logic                cdb_mispredict,
    input  logic [DATA_W-1:0]   cdb_target,
    output logic                unlock,
    output logic [REG_W-1:0]    unlock_rd,
    output logic [ROB_BITS-1:0] unlock_robpos,
    output logic [DATA_W-1:0]   unlock_val,
    output logic                clear,
    output logic [DATA_W-1:0]   redirect_pc,
    output logic [ROB_BITS:0]   rob_count
);

    localparam int DEPTH = 1 << ROB_BITS;
    localparam logic [ROB_BITS:0] FULL_COUNT = (ROB_BITS+1)'(DEPTH);

    logic [ROB_BITS-1:0] head;
    logic [ROB_BITS-1:0] tail;
    logic [ROB_BITS:0]   count;
    logic [DEPTH-1:0]    busy;
    logic [DEPTH-1:0]    done;

    logic [REG_W-1:0]    rd_mem     [DEPTH];
    logic [DATA_W-1:0]   val_mem    [DEPTH];
    logic [DATA_W-1:0]   target_mem [DEPTH];
    logic                mp_mem     [DEPTH];

    logic commit;
    logic alloc_fire;
    logic cdb_fire;

    assign alloc_full   = (count == FULL_COUNT);
    assign alloc_robpos = tail;
    assign rob_count    = count;

    // Commit looks only at registered done, so a completion to head retires next cycle.
    assign commit     = ready && (count != '0) && done[head];
    assign alloc_fire = ready && !clear && alloc_valid && !alloc_full;
    assign cdb_fire   = cdb_valid && busy[cdb_robpos] && !clear;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        unlock        = 1'b0;
        unlock_rd     = '0;
        unlock_robpos = '0;
        unlock_val    = '0;
        clear         = 1'b0;
        redirect_pc   = '0;
        if (commit) begin
            unlock        = 1'b1;
            unlock_rd     = rd_mem[head];
            unlock_robpos = head;
            unlock_val    = val_mem[head];
            if (mp_mem[head]) begin
                clear       = 1'b1;
                redirect_pc = target_mem[head];
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
        end else begin
            if (cdb_fire) begin
                done[cdb_robpos] <= 1'b1;
            end
            if (alloc_fire) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + ROB_BITS'(1);
            end
            if (commit) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + ROB_BITS'(1);
            end
            case ({alloc_fire, commit})
                2'b10:   count <= count + (ROB_BITS+1)'(1);
                2'b01:   count <= count - (ROB_BITS+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage is not reset; busy/done gate every observable use of it.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            rd_mem[tail] <= alloc_rd;
        end
        if (cdb_fire) begin
            val_mem[cdb_robpos]    <= cdb_val;
            mp_mem[cdb_robpos]     <= cdb_mispredict;
            target_mem[cdb_robpos] <= cdb_target;
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a vector table for ordering and rd=0 cases,
// then hand sequences for full, mispredict flush, stall and asynchronous reset.
module tb_rob_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        alloc_valid;
    logic [4:0]  alloc_rd;
    logic        alloc_full;
    logic [3:0]  alloc_robpos;
    logic        cdb_valid;
    logic [3:0]  cdb_robpos;
    logic [31:0] cdb_val;
    logic        cdb_mispredict;
    logic [31:0] cdb_target;
    logic        unlock;
    logic [4:0]  unlock_rd;
    logic [3:0]  unlock_robpos;
    logic [31:0] unlock_val;
    logic        clear;
    logic [31:0] redirect_pc;
    logic [4:0]  rob_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rob_commit #(.ROB_BITS(4), .DATA_W(32), .REG_W(5)) dut (
        .clk            (clk),
        .reset          (reset),
        .ready          (ready),
        .alloc_valid    (alloc_valid),
        .alloc_rd       (alloc_rd),
        .alloc_full     (alloc_full),
        .alloc_robpos   (alloc_robpos),
        .cdb_valid      (cdb_valid),
        .cdb_robpos     (cdb_robpos),
        .cdb_val        (cdb_val),
        .cdb_mispredict (cdb_mispredict),
        .cdb_target     (cdb_target),
        .unlock         (unlock),
        .unlock_rd      (unlock_rd),
        .unlock_robpos  (unlock_robpos),
        .unlock_val     (unlock_val),
        .clear          (clear),
        .redirect_pc    (redirect_pc),
        .rob_count      (rob_count)
    );

    typedef struct {
        logic        ready;
        logic        av;
        logic [4:0]  ard;
        logic        cv;
        logic [3:0]  cpos;
        logic [31:0] cval;
        logic        cmp;
        logic [31:0] ctgt;
        logic        eu;
        logic [4:0]  erd;
        logic [3:0]  epos;
        logic [31:0] eval;
        logic        eclr;
        logic [31:0] epc;
        logic [4:0]  ecnt;
        logic        efull;
        logic [3:0]  etail;
    } vec_t;

    function automatic vec_t mk(int rdy, int av, int ard, int cv, int cpos, int cval,
                                int cmp, int ctgt, int eu, int erd, int epos, int eval,
                                int eclr, int epc, int ecnt, int efull, int etail);
        vec_t v;
        v.ready = 1'(rdy);  v.av = 1'(av);     v.ard = 5'(ard);
        v.cv = 1'(cv);      v.cpos = 4'(cpos); v.cval = 32'(cval);
        v.cmp = 1'(cmp);    v.ctgt = 32'(ctgt);
        v.eu = 1'(eu);      v.erd = 5'(erd);   v.epos = 4'(epos);
        v.eval = 32'(eval); v.eclr = 1'(eclr); v.epc = 32'(epc);
        v.ecnt = 5'(ecnt);  v.efull = 1'(efull); v.etail = 4'(etail);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ready = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
        cdb_valid = 1'b0; cdb_robpos = '0; cdb_val = '0;
        cdb_mispredict = 1'b0; cdb_target = '0;
    endtask

    // Drive at the falling edge, check outputs 1ns later, let the next rising edge apply.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        ready = v.ready; alloc_valid = v.av; alloc_rd = v.ard;
        cdb_valid = v.cv; cdb_robpos = v.cpos; cdb_val = v.cval;
        cdb_mispredict = v.cmp; cdb_target = v.ctgt;
        #1;
        check({tag, ".unlock"},        32'(unlock),        32'(v.eu));
        check({tag, ".unlock_rd"},     32'(unlock_rd),     32'(v.erd));
        check({tag, ".unlock_robpos"}, 32'(unlock_robpos), 32'(v.epos));
        check({tag, ".unlock_val"},    unlock_val,         v.eval);
        check({tag, ".clear"},         32'(clear),         32'(v.eclr));
        check({tag, ".redirect_pc"},   redirect_pc,        v.epc);
        check({tag, ".rob_count"},     32'(rob_count),     32'(v.ecnt));
        check({tag, ".alloc_full"},    32'(alloc_full),    32'(v.efull));
        check({tag, ".alloc_robpos"},  32'(alloc_robpos),  32'(v.etail));
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    vec_t tbl [16];

    initial begin
        drive_idle();
        ready = 1'b0;
        reset = 1'b1;
        #12;
        check("reset.rob_count",    32'(rob_count),    32'd0);
        check("reset.unlock",       32'(unlock),       32'd0);
        check("reset.clear",        32'(clear),        32'd0);
        check("reset.alloc_full",   32'(alloc_full),   32'd0);
        check("reset.alloc_robpos", 32'(alloc_robpos), 32'd0);
        check("reset.redirect_pc",  redirect_pc,       32'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Out-of-order completion retires in order; rd=0 entry still unlocks.
        tbl[0]  = mk(1,1,3, 0,0,0,0,0,       0,0,0,0,       0,0, 0,0,0);
        tbl[1]  = mk(1,1,4, 0,0,0,0,0,       0,0,0,0,       0,0, 1,0,1);
        tbl[2]  = mk(1,1,5, 0,0,0,0,0,       0,0,0,0,       0,0, 2,0,2);
        tbl[3]  = mk(1,0,0, 1,2,'h22,0,0,    0,0,0,0,       0,0, 3,0,3);
        tbl[4]  = mk(1,0,0, 1,0,'h11,0,0,    0,0,0,0,       0,0, 3,0,3);
        tbl[5]  = mk(1,0,0, 1,1,'h33,0,0,    1,3,0,'h11,    0,0, 3,0,3);
        tbl[6]  = mk(1,0,0, 0,0,0,0,0,       1,4,1,'h33,    0,0, 2,0,3);
        tbl[7]  = mk(1,0,0, 0,0,0,0,0,       1,5,2,'h22,    0,0, 1,0,3);
        tbl[8]  = mk(1,0,0, 0,0,0,0,0,       0,0,0,0,       0,0, 0,0,3);
        tbl[9]  = mk(1,1,0, 0,0,0,0,0,       0,0,0,0,       0,0, 0,0,3);
        tbl[10] = mk(1,1,7, 0,0,0,0,0,       0,0,0,0,       0,0, 1,0,4);
        tbl[11] = mk(1,0,0, 1,9,'hdead,0,0,  0,0,0,0,       0,0, 2,0,5);
        tbl[12] = mk(1,0,0, 1,3,'h55,0,0,    0,0,0,0,       0,0, 2,0,5);
        tbl[13] = mk(1,0,0, 1,4,'h66,0,0,    1,0,3,'h55,    0,0, 2,0,5);
        tbl[14] = mk(1,0,0, 0,0,0,0,0,       1,7,4,'h66,    0,0, 1,0,5);
        tbl[15] = mk(1,0,0, 0,0,0,0,0,       0,0,0,0,       0,0, 0,0,5);
        for (int i = 0; i < 16; i++) apply(tbl[i], $sformatf("tbl%0d", i));

        // Full: 17th alloc dropped, alloc in the commit cycle still blocked, then wraps to 0.
        do_reset();
        for (int i = 0; i < 16; i++) apply(mk(1,1,i+1, 0,0,0,0,0, 0,0,0,0, 0,0, i,0,i), $sformatf("fill%0d", i));
        apply(mk(1,1,9,  0,0,0,0,0,      0,0,0,0,     0,0, 16,1,0), "full.drop");
        apply(mk(1,1,9,  1,0,'hAA,0,0,   0,0,0,0,     0,0, 16,1,0), "full.cdb");
        apply(mk(1,1,20, 0,0,0,0,0,      1,1,0,'hAA,  0,0, 16,1,0), "full.commit");
        apply(mk(1,1,20, 0,0,0,0,0,      0,0,0,0,     0,0, 15,0,0), "full.accept");
        apply(mk(1,0,0,  0,0,0,0,0,      0,0,0,0,     0,0, 16,1,1), "full.after");

        // Mispredict at pos 4 flushes younger completed entries; alloc in flush cycle discarded.
        do_reset();
        for (int i = 0; i < 8; i++) apply(mk(1,1,i+1, 0,0,0,0,0, 0,0,0,0, 0,0, i,0,i), $sformatf("mp.alloc%0d", i));
        apply(mk(1,0,0, 1,5,'h55,0,0,       0,0,0,0, 0,0, 8,0,8), "mp.c5");
        apply(mk(1,0,0, 1,6,'h66,0,0,       0,0,0,0, 0,0, 8,0,8), "mp.c6");
        apply(mk(1,0,0, 1,7,'h77,0,0,       0,0,0,0, 0,0, 8,0,8), "mp.c7");
        apply(mk(1,0,0, 1,4,'h44,1,'h1000,  0,0,0,0, 0,0, 8,0,8), "mp.c4");
        apply(mk(1,0,0, 1,1,'h11,0,0,       0,0,0,0, 0,0, 8,0,8), "mp.c1");
        apply(mk(1,0,0, 1,2,'h22,0,0,       0,0,0,0, 0,0, 8,0,8), "mp.c2");
        apply(mk(1,0,0, 1,3,'h33,0,0,       0,0,0,0, 0,0, 8,0,8), "mp.c3");
        apply(mk(1,0,0, 1,0,'h10,0,0,       0,0,0,0, 0,0, 8,0,8), "mp.c0");
        apply(mk(1,0,0, 0,0,0,0,0, 1,1,0,'h10, 0,0,       8,0,8), "mp.r0");
        apply(mk(1,0,0, 0,0,0,0,0, 1,2,1,'h11, 0,0,       7,0,8), "mp.r1");
        apply(mk(1,0,0, 0,0,0,0,0, 1,3,2,'h22, 0,0,       6,0,8), "mp.r2");
        apply(mk(1,0,0, 0,0,0,0,0, 1,4,3,'h33, 0,0,       5,0,8), "mp.r3");
        apply(mk(1,1,9, 0,0,0,0,0, 1,5,4,'h44, 1,'h1000,  4,0,8), "mp.r4");
        apply(mk(1,0,0, 0,0,0,0,0, 0,0,0,0,    0,0,       0,0,0), "mp.flushed");
        apply(mk(1,0,0, 0,0,0,0,0, 0,0,0,0,    0,0,       0,0,0), "mp.quiet");

        // Stall: head done but ready=0 for 3 cycles; CDB during stall kept; alloc ignored.
        apply(mk(1,1,10, 0,0,0,0,0,      0,0,0,0,      0,0, 0,0,0), "st.a0");
        apply(mk(1,1,11, 0,0,0,0,0,      0,0,0,0,      0,0, 1,0,1), "st.a1");
        apply(mk(1,0,0,  1,0,'hA0,0,0,   0,0,0,0,      0,0, 2,0,2), "st.c0");
        apply(mk(0,1,12, 1,1,'hA1,0,0,   0,0,0,0,      0,0, 2,0,2), "st.s0");
        apply(mk(0,0,0,  0,0,0,0,0,      0,0,0,0,      0,0, 2,0,2), "st.s1");
        apply(mk(0,0,0,  0,0,0,0,0,      0,0,0,0,      0,0, 2,0,2), "st.s2");
        apply(mk(1,0,0,  0,0,0,0,0,      1,10,0,'hA0,  0,0, 2,0,2), "st.r0");
        apply(mk(1,0,0,  0,0,0,0,0,      1,11,1,'hA1,  0,0, 1,0,2), "st.r1");
        apply(mk(1,0,0,  0,0,0,0,0,      0,0,0,0,      0,0, 0,0,2), "st.done");

        // Asynchronous reset mid-run with 5 entries and a committable head.
        for (int i = 0; i < 5; i++) apply(mk(1,1,i+1, 0,0,0,0,0, 0,0,0,0, 0,0, i,0,i+2), $sformatf("rr.alloc%0d", i));
        apply(mk(1,0,0, 1,2,'h77,0,0,  0,0,0,0,     0,0, 5,0,7), "rr.cdb");
        apply(mk(1,0,0, 0,0,0,0,0,     1,1,2,'h77,  0,0, 5,0,7), "rr.pre");
        #1 reset = 1'b1;
        #1;
        check("rr.async.rob_count",    32'(rob_count),    32'd0);
        check("rr.async.unlock",       32'(unlock),       32'd0);
        check("rr.async.unlock_val",   unlock_val,        32'd0);
        check("rr.async.clear",        32'(clear),        32'd0);
        check("rr.async.alloc_robpos", 32'(alloc_robpos), 32'd0);
        @(negedge clk);
        drive_idle();
        #2 reset = 1'b0;
        apply(mk(1,1,9, 0,0,0,0,0, 0,0,0,0, 0,0, 0,0,0), "rr.resume");
        apply(mk(1,0,0, 0,0,0,0,0, 0,0,0,0, 0,0, 1,0,1), "rr.after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
